// File: rtl/saturating_counter_table_if.sv
// Predictor-side bundle for the pattern-history counter table:
// read index/prediction plus the resolved-branch training fields.
interface saturating_counter_table_if #(
    parameter int INDEX = 10
);
    logic             stall;
    logic [INDEX-1:0] pred_sel;
    logic [INDEX-1:0] update_sel;
    logic             update;
    logic             up_down;
    logic             pred;

    modport master (
        output stall,
        output pred_sel,
        output update_sel,
        output update,
        output up_down,
        input  pred
    );

    modport slave (
        input  stall,
        input  pred_sel,
        input  update_sel,
        input  update,
        input  up_down,
        output pred
    );
endinterface

// File: rtl/saturating_counter_table.sv
// Pattern-history table of saturating up/down counters for the
// local branch predictor: combinational read, one trained entry per cycle.
module saturating_counter_table #(
    parameter int WIDTH    = 1024,
    parameter int INDEX    = 10,
    parameter int CTR_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    saturating_counter_table_if.slave  bus
);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

    logic [CTR_BITS-1:0] ctr [WIDTH];
    logic [CTR_BITS-1:0] cur;
    logic [CTR_BITS-1:0] nxt;
    logic                wr;

    // No bypass: a same-index read sees the pre-update value this cycle.
    assign bus.pred = ctr[bus.pred_sel][CTR_BITS-1];

    assign cur = ctr[bus.update_sel];
    assign wr  = bus.update && !bus.stall;

    always_comb begin
        nxt = cur;
        if (bus.up_down) begin
            if (cur != CTR_MAX) nxt = cur + CTR_ONE;
        end else begin
            if (cur != CTR_MIN) nxt = cur - CTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (wr) begin
            ctr[bus.update_sel] <= nxt;
        end
    end
endmodule

// File: tb/tb_saturating_counter_table.sv
// Scoreboard bench for saturating_counter_table: a counter model
// supplies expected predictions, queued at drive time and popped at sample.
module tb_saturating_counter_table;
    localparam int WIDTH = 1024;
    localparam int INDEX = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;

    saturating_counter_table_if #(.INDEX(INDEX)) bus ();

    saturating_counter_table #(
        .WIDTH(WIDTH), .INDEX(INDEX), .CTR_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   model [WIDTH];
    logic exp_q [$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic exp_pred(input int idx);
        return (model[idx] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) model[i] = 1;
    endtask

    task automatic model_train(input int idx, input logic d);
        if (d) model[idx] = (model[idx] == 3) ? 3 : model[idx] + 1;
        else   model[idx] = (model[idx] == 0) ? 0 : model[idx] - 1;
    endtask

    task automatic step(input logic s, input logic u, input logic d, input int idx);
        logic [INDEX-1:0] sel;
        sel = idx[INDEX-1:0];
        @(negedge clk);
        bus.stall = s;
        bus.update = u;
        bus.up_down = d;
        bus.update_sel = sel;
        @(posedge clk);
        if (reset && !s && u) model_train(idx, d);
        #1;
        bus.update = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        int idxs [4] = '{0, 1, 512, 1023};
        logic e;
        logic [INDEX-1:0] sel;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        foreach (idxs[i]) begin
            sel = idxs[i][INDEX-1:0];
            bus.pred_sel = sel;
            exp_q.push_back(exp_pred(idxs[i]));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL reset_in_%0d got=%b exp=%b", idxs[i], bus.pred, e);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        foreach (idxs[i]) begin
            sel = idxs[i][INDEX-1:0];
            bus.pred_sel = sel;
            exp_q.push_back(exp_pred(idxs[i]));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL reset_out_%0d got=%b exp=%b", idxs[i], bus.pred, e);
            end
        end
    endtask

    task automatic test_promote();
        logic dirs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic want [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic e;
        bus.pred_sel = 10'd5;
        foreach (dirs[i]) begin
            step(1'b0, 1'b1, dirs[i], 5);
            exp_q.push_back(exp_pred(5));
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e || e !== want[i]) begin
                failures++;
                $display("FAIL promote_%0d got=%b exp=%b", i, bus.pred, want[i]);
            end
        end
    endtask

    task automatic test_low_sat();
        logic dirs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic want [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e;
        bus.pred_sel = 10'd7;
        foreach (dirs[i]) begin
            step(1'b0, 1'b1, dirs[i], 7);
            exp_q.push_back(exp_pred(7));
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e || e !== want[i]) begin
                failures++;
                $display("FAIL low_sat_%0d got=%b exp=%b", i, bus.pred, want[i]);
            end
        end
    endtask

    task automatic test_stall();
        int others [4] = '{8, 10, 5, 7};
        logic e;
        logic [INDEX-1:0] sel;
        bus.pred_sel = 10'd9;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 9);
            exp_q.push_back(exp_pred(9));
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL stall_%0d got=%b exp=%b", i, bus.pred, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 9);
            exp_q.push_back(exp_pred(9));
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL noupd_%0d got=%b exp=%b", i, bus.pred, e);
            end
        end
        // One genuine update afterwards shows index 9 was trainable.
        step(1'b0, 1'b1, 1'b1, 9);
        exp_q.push_back(exp_pred(9));
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e || e !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%b exp=1", bus.pred);
        end
        foreach (others[i]) begin
            sel = others[i][INDEX-1:0];
            bus.pred_sel = sel;
            exp_q.push_back(exp_pred(others[i]));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL neighbour_%0d got=%b exp=%b", others[i], bus.pred, e);
            end
        end
    endtask

    task automatic test_same_index();
        logic e;
        @(negedge clk);
        bus.pred_sel = 10'd3;
        bus.update_sel = 10'd3;
        bus.update = 1'b1;
        bus.up_down = 1'b1;
        exp_q.push_back(exp_pred(3));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e || e !== 1'b0) begin
            failures++;
            $display("FAIL same_pre got=%b exp=0", bus.pred);
        end
        @(posedge clk);
        model_train(3, 1'b1);
        exp_q.push_back(exp_pred(3));
        #1;
        bus.update = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e || e !== 1'b1) begin
            failures++;
            $display("FAIL same_post got=%b exp=1", bus.pred);
        end
        bus.pred_sel = 10'd4;
        exp_q.push_back(exp_pred(4));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e) begin
            failures++;
            $display("FAIL same_idx4 got=%b exp=%b", bus.pred, e);
        end
    endtask

    task automatic test_async_reset();
        logic e;
        bus.pred_sel = 10'd1023;
        step(1'b0, 1'b1, 1'b1, 1023);
        step(1'b0, 1'b1, 1'b1, 1023);
        exp_q.push_back(exp_pred(1023));
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e || e !== 1'b1) begin
            failures++;
            $display("FAIL async_trained got=%b exp=1", bus.pred);
        end
        @(negedge clk);
        #1;
        bus.update_sel = 10'd1023;
        bus.up_down = 1'b1;
        bus.update = 1'b1;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(exp_pred(1023));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e) begin
            failures++;
            $display("FAIL async_drop got=%b exp=%b", bus.pred, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.pred !== 1'b0) begin
            failures++;
            $display("FAIL async_prio got=%b exp=0", bus.pred);
        end
        bus.update = 1'b0;
        bus.pred_sel = 10'd7;
        exp_q.push_back(exp_pred(7));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e) begin
            failures++;
            $display("FAIL async_idx7 got=%b exp=%b", bus.pred, e);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.pred_sel = 10'd1023;
        step(1'b0, 1'b1, 1'b1, 1023);
        exp_q.push_back(exp_pred(1023));
        e = exp_q.pop_front();
        checks++;
        if (bus.pred !== e || e !== 1'b1) begin
            failures++;
            $display("FAIL async_after got=%b exp=1", bus.pred);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int rd;
        logic s;
        logic u;
        logic d;
        logic e;
        logic [INDEX-1:0] sel;
        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 15);
            rd  = $urandom_range(0, 15);
            s = ($urandom_range(0, 7) == 0);
            u = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 1) != 0;
            step(s, u, d, idx);
            sel = rd[INDEX-1:0];
            bus.pred_sel = sel;
            exp_q.push_back(exp_pred(rd));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.pred !== e) begin
                failures++;
                $display("FAIL b2b_%0d idx=%0d got=%b exp=%b", i, rd, bus.pred, e);
            end
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.update = 1'b0;
        bus.up_down = 1'b0;
        bus.pred_sel = '0;
        bus.update_sel = '0;
        test_reset();
        test_promote();
        test_low_sat();
        test_stall();
        test_same_index();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end
endmodule

// File: doc/saturating_counter_table.md
Name: saturating_counter_table

Overview:
- Indexed table of saturating up/down counters forming the pattern-history stage of the local branch predictor.
- The predictor supplies a history value as a read index and receives a 1-bit taken/not-taken prediction combinationally.
- A delayed (resolved) history value selects the entry to train when a branch resolves in ID.

Parameters:
- WIDTH, 1024, number of counter entries; must equal 2**INDEX.
- INDEX, 10, width of the select/index ports.
- CTR_BITS, 2, width of each saturating counter; minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline stall; when high, no entry changes.
- pred_sel  input  INDEX  read index for the prediction.
- update_sel  input  INDEX  index of the entry to train.
- update  input  1  train enable (resolved instruction is a branch).
- up_down  input  1  training direction: 1 = taken (increment), 0 = not taken (decrement).
- pred  output  1  prediction: MSB of counter[pred_sel]; 1 = taken.

Behaviour:
- Storage: WIDTH counters, each CTR_BITS wide, unsigned.
- Reset (reset low, asynchronous): every counter is forced to the weakly-not-taken value 2**(CTR_BITS-1)-1 (01 for 2-bit).
  - Consequently pred = 0 for every index while in, and immediately after, reset.
  - Reset takes priority over everything, including an in-progress update.
- Read path: pred = counter[pred_sel][CTR_BITS-1], purely combinational with no latency.
  - pred changes in the same cycle as pred_sel.
  - pred also changes immediately after an edge that modifies the selected entry.
- Training, on each rising clk with reset high:
  - If stall = 1: no change, regardless of update.
  - Else if update = 1 and up_down = 1: counter[update_sel] increments, saturating at 2**CTR_BITS-1 (11).
  - Else if update = 1 and up_down = 0: counter[update_sel] decrements, saturating at 0.
  - Else: no change.
- Exactly one entry is modified per cycle at most; all other entries hold.
- pred_sel == update_sel in the same cycle: pred shows the pre-update value during that cycle and the updated value after the edge (no write-through bypass).
- Indices are used directly (no hashing); every value 0..WIDTH-1 is valid.
- 2-bit state encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Transitions: taken moves 00→01→10→11→11.
  - Not-taken moves 11→10→01→00→00.
- No X propagation: outputs are defined from reset onward.

Test Plan:
- Reset and read: assert reset low, release; sweep pred_sel over 0, 1, 512, 1023 → pred = 0 at each.
- Promotion and saturation: update_sel = 5, update = 1, up_down = 1 for 1 cycle → pred at pred_sel = 5 becomes 1 (counter 10).
  - 3 more taken updates → counter stays 11, pred = 1.
  - 1 not-taken → counter 10, pred = 1.
  - 2nd not-taken → counter 01, pred = 0.
- Low saturation: index 7, four not-taken updates from reset → counter 00, pred = 0.
  - 1 taken → counter 01, pred = 0.
  - 2nd taken → counter 10, pred = 1.
- Stall and enable gating:
  - Index 9 with stall = 1, update = 1, up_down = 1 for 5 cycles → pred at 9 stays 0.
  - Same with stall = 0, update = 0 → pred stays 0.
  - Any index other than 9 is never disturbed.
- Same-index read/write: pred_sel = update_sel = 3, counter 01, taken update → pred = 0 before the edge, 1 after it.
  - Index 4 is unaffected, pred = 0.
- Async reset mid-operation:
  - Train index 1023 to 11.
  - Drop reset between clock edges → pred at 1023 goes to 0 immediately, without a clock edge.
  - Release reset → an update at the next edge applies normally from 01.
